sgdmac_burst_arb: RTL and testbench
===================================

SGDMAC_BURST_ARB -- requirements
Module: sgdmac_burst_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_SIZE, default 32, beat width in bits.
REQ-003 Parameter WEIGHT_W, default 4, per-requester weight width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid_i  input  N_REQ  per-requester beat valid.
REQ-008 req_ready_o  output  N_REQ  per-requester beat accept.
REQ-009 req_data_i  input  N_REQ*DATA_SIZE  packed beats; requester k at bits [k*DATA_SIZE +: DATA_SIZE].
REQ-010 req_last_i  input  N_REQ  final beat of the requester's burst.
REQ-011 weight_i  input  N_REQ*WEIGHT_W  packed bursts-per-turn; 0 disables the requester.
REQ-012 dst_valid_o  output  1  merged beat valid.
REQ-013 dst_ready_i  input  1  downstream accept.
REQ-014 dst_data_o  output  DATA_SIZE  merged beat data.
REQ-015 dst_last_o  output  1  merged burst end.
REQ-016 grant_id_o  output  clog2(N_REQ)  index of current owner.
REQ-017 busy_o  output  1  high while state is BURST.

Function
REQ-018 The block SHALL implement two states: IDLE (no owner) and BURST (owner locked).
REQ-019 Eligible requester k: req_valid_i[k]=1 and weight_i[k]!=0.
REQ-020 In IDLE, on a clock edge with any eligible requester, the block SHALL grant the first eligible index searching upward (wrapping) from rr_ptr, load grant_id_o with it, load credit with its weight, and enter BURST.
REQ-021 In IDLE, dst_valid_o, dst_last_o and all req_ready_o SHALL be 0 and dst_data_o SHALL be 0.
REQ-022 In BURST, outputs SHALL be combinational pass-through of owner g: dst_valid_o=req_valid_i[g], dst_data_o=req_data_i[g], dst_last_o=req_last_i[g], req_ready_o[g]=dst_ready_i, other req_ready_o bits 0.
REQ-023 Latency: first beat SHALL appear at dst one cycle after the requester's valid is sampled in IDLE; no latency inside a burst.
REQ-024 Ownership SHALL NOT change until a beat with dst_valid_o & dst_ready_i & dst_last_o completes (burst end).
REQ-025 At burst end credit SHALL decrement by 1; if the new credit is nonzero and req_valid_i[g]=1 in that cycle, the block SHALL stay in BURST with the same owner (zero-bubble back-to-back).
REQ-026 Otherwise at burst end the block SHALL set rr_ptr=(g+1) mod N_REQ and return to IDLE.
REQ-027 Weight changes SHALL take effect only at the next credit load; a weight forced to 0 mid-burst SHALL NOT abort the burst.
REQ-028 A requester deasserting valid mid-burst SHALL stall dst (dst_valid_o=0) without losing ownership.
REQ-029 credit SHALL be WEIGHT_W bits and never underflow; a load of weight W grants at most W consecutive bursts.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, rr_ptr=0, credit=0, grant_id_o=0, busy_o=0, all outputs 0, including mid-burst.
REQ-031 After rst deasserts, arbitration SHALL begin on the first clock edge with an eligible requester.

Verification
REQ-032 All 4 requesters valid, single-beat bursts, weights 1, dst_ready_i=1 -> grant order 0,1,2,3,0 with one IDLE cycle between bursts.
REQ-033 Requester 1 weight 3, continuous 2-beat bursts, others idle -> three bursts back-to-back with no bubble, then one IDLE cycle, then re-grant to 1.
REQ-034 Requester 2 weight 0 with valid held, requester 3 valid weight 1 -> only 3 granted; req_ready_o[2] never 1.
REQ-035 Owner 0 drops valid for 3 cycles mid 4-beat burst while requester 1 valid -> dst_valid_o=0 for those cycles, grant_id_o stays 0, all 4 beats delivered in order before 1 is granted.
REQ-036 dst_ready_i held low during last beat for 5 cycles -> beat, data and dst_last_o stable, no state change until accepted.
REQ-037 rst pulsed mid-burst of requester 2 -> outputs 0 same cycle, busy_o=0; next grant follows rr_ptr=0 search.

Source files
------------

// File: rtl/sgdmac_burst_arb_if.sv
// Requester/downstream bundle for the weighted burst arbiter.
// The slave modport is the arbiter's view; master is the traffic side.
interface sgdmac_burst_arb_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_SIZE = 32,
    parameter int WEIGHT_W  = 4
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]           req_valid_i;
    logic [N_REQ-1:0]           req_ready_o;
    logic [N_REQ*DATA_SIZE-1:0] req_data_i;
    logic [N_REQ-1:0]           req_last_i;
    logic [N_REQ*WEIGHT_W-1:0]  weight_i;
    logic                       dst_valid_o;
    logic                       dst_ready_i;
    logic [DATA_SIZE-1:0]       dst_data_o;
    logic                       dst_last_o;
    logic [GID_W-1:0]           grant_id_o;
    logic                       busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, weight_i, dst_ready_i,
        output req_ready_o, dst_valid_o, dst_data_o, dst_last_o, grant_id_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, weight_i, dst_ready_i,
        input  req_ready_o, dst_valid_o, dst_data_o, dst_last_o, grant_id_o, busy_o
    );
endinterface

// File: rtl/sgdmac_burst_arb.sv
// Weighted round-robin burst arbiter: locks one requester for a burst and
// lets it run up to weight back-to-back bursts before passing the turn on.
module sgdmac_burst_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_SIZE = 32,
    parameter int WEIGHT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    sgdmac_burst_arb_if.slave bus
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [GID_W-1:0]    grant_q, grant_d;
    logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;

    logic [N_REQ-1:0]     elig;
    logic                 found;
    logic [GID_W-1:0]     pick;
    int                   idx;
    logic                 busy;
    logic                 own_valid, own_last, beat_end;
    logic [DATA_SIZE-1:0] own_data;
    logic [N_REQ-1:0]     ready_vec;

    for (genvar k = 0; k < N_REQ; k++) begin : g_elig
        assign elig[k] = bus.req_valid_i[k] &&
                         (bus.weight_i[k*WEIGHT_W +: WEIGHT_W] != '0);
    end

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % N_REQ;
            if (elig[idx]) begin
                found = 1'b1;
                pick  = GID_W'(idx);
            end
        end
    end

    assign busy      = (state_q == ST_BURST);
    assign own_valid = bus.req_valid_i[grant_q];
    assign own_last  = bus.req_last_i[grant_q];
    assign own_data  = bus.req_data_i[int'(grant_q)*DATA_SIZE +: DATA_SIZE];
    assign beat_end  = busy && own_valid && bus.dst_ready_i && own_last;

    always_comb begin
        ready_vec = '0;
        if (busy) ready_vec[grant_q] = bus.dst_ready_i;
    end

    assign bus.req_ready_o = ready_vec;
    assign bus.dst_valid_o = busy && own_valid;
    assign bus.dst_last_o  = busy && own_last;
    assign bus.dst_data_o  = busy ? own_data : '0;
    assign bus.grant_id_o  = grant_q;
    assign bus.busy_o      = busy;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_BURST;
                    grant_d  = pick;
                    credit_d = bus.weight_i[int'(pick)*WEIGHT_W +: WEIGHT_W];
                end
            end
            default: begin
                if (beat_end) begin
                    credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
                    // Weight is not re-read here; only a fresh grant reloads it.
                    if (credit_d == '0 || !own_valid) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end
endmodule

// File: tb/tb_sgdmac_burst_arb.sv
// Randomized and directed bench for sgdmac_burst_arb with a cycle-level
// reference model of owner, turn pointer and remaining bursts.
module tb_sgdmac_burst_arb;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sgdmac_burst_arb_if #(.N_REQ(N), .DATA_SIZE(DW), .WEIGHT_W(WW)) bus ();

    sgdmac_burst_arb #(.N_REQ(N), .DATA_SIZE(DW), .WEIGHT_W(WW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // traffic sources
    bit en[N];
    int bi[N], blen[N], seq[N], hold_cnt[N], hold_at[N];
    int len_lo[N], len_hi[N], stall_pct[N];
    bit fired[N];
    int rdy_pct, blk_last;

    // monitor / log
    int cyc = 0;
    int f_gid[$];
    int f_cyc[$];
    logic [DW-1:0] f_data[$];
    bit r2_seen;
    int gap0, lstall, lstall_max;
    bit hold_seen;
    logic [DW-1:0] h_data;
    logic h_last;

    // reference model: owner=-1 means no owner
    int m_own = -1, m_rr = 0, m_cred = 0, m_gid = 0;

    function automatic int wt(input int j);
        return int'(bus.weight_i[j*WW +: WW]);
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] e_rdy;
        logic e_v, e_l;
        logic [DW-1:0] e_d;
        bit fnd;
        cyc++;
        if (rst) begin m_own = -1; m_rr = 0; m_cred = 0; m_gid = 0; end
        e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0;
        if (m_own >= 0) begin
            e_v = bus.req_valid_i[m_own];
            e_l = bus.req_last_i[m_own];
            e_d = bus.req_data_i[m_own*DW +: DW];
            e_rdy[m_own] = bus.dst_ready_i;
        end
        chk("dst_valid", bus.dst_valid_o, e_v);
        chk("dst_last", bus.dst_last_o, e_l);
        chk("dst_data", bus.dst_data_o, e_d);
        chk("req_ready", bus.req_ready_o, e_rdy);
        chk("busy", bus.busy_o, (m_own >= 0));
        chk("grant_id", bus.grant_id_o, m_gid);

        if (bus.req_ready_o[2]) r2_seen = 1'b1;
        if (bus.busy_o && bus.grant_id_o == 0 && !bus.dst_valid_o) gap0++;
        if (bus.dst_valid_o && !bus.dst_ready_i) begin
            if (hold_seen) begin
                chk("stall_data", bus.dst_data_o, h_data);
                chk("stall_last", bus.dst_last_o, h_last);
            end
            hold_seen = 1'b1; h_data = bus.dst_data_o; h_last = bus.dst_last_o;
            if (bus.dst_last_o) begin
                lstall++;
                if (lstall > lstall_max) lstall_max = lstall;
            end
        end else begin
            hold_seen = 1'b0; lstall = 0;
        end
        if (bus.dst_valid_o && bus.dst_ready_i) begin
            f_gid.push_back(int'(bus.grant_id_o));
            f_cyc.push_back(cyc);
            f_data.push_back(bus.dst_data_o);
        end
        for (int k = 0; k < N; k++) fired[k] = bus.req_valid_i[k] & bus.req_ready_o[k];

        // advance model with the inputs the next rising edge will sample
        if (!rst) begin
            if (m_own < 0) begin
                fnd = 1'b0;
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (m_rr + i) % N;
                    if (!fnd && bus.req_valid_i[j] && wt(j) != 0) begin
                        fnd = 1'b1; m_own = j; m_gid = j; m_cred = wt(j);
                    end
                end
            end else if (bus.req_valid_i[m_own] && bus.dst_ready_i && bus.req_last_i[m_own]) begin
                m_cred = m_cred - 1;
                if (m_cred == 0) begin
                    m_rr = (m_own + 1) % N;
                    m_own = -1;
                end
            end
        end
    end

    task automatic src_clear();
        for (int k = 0; k < N; k++) begin
            en[k] = 1'b0; bi[k] = 0; blen[k] = 0; seq[k] = 0; hold_cnt[k] = 0;
            hold_at[k] = -1; fired[k] = 1'b0; len_lo[k] = 1; len_hi[k] = 1; stall_pct[k] = 0;
        end
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
    endtask

    task automatic src_cfg(input int k, input bit e, input int lo, input int hi, input int st);
        en[k] = e; len_lo[k] = lo; len_hi[k] = hi; stall_pct[k] = st;
    endtask

    task automatic drive();
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            if (fired[k]) begin
                fired[k] = 1'b0;
                seq[k]++;
                if (hold_at[k] == bi[k]) begin hold_cnt[k] = 3; hold_at[k] = -1; end
                if (bi[k] >= blen[k] - 1) begin bi[k] = 0; blen[k] = 0; end
                else bi[k]++;
            end
            if (blen[k] == 0) blen[k] = int'($urandom_range(len_hi[k], len_lo[k]));
            if (hold_cnt[k] > 0) begin
                bus.req_valid_i[k] = 1'b0;
                hold_cnt[k]--;
            end else begin
                bus.req_valid_i[k] = en[k] && (int'($urandom_range(99)) >= stall_pct[k]);
            end
            bus.req_data_i[k*DW +: DW] = {8'(k), 24'(seq[k])};
            bus.req_last_i[k] = (bi[k] == blen[k] - 1);
        end
        #1;
        if (blk_last > 0 && bus.dst_valid_o && bus.dst_last_o) begin
            bus.dst_ready_i = 1'b0;
            blk_last--;
        end else begin
            bus.dst_ready_i = (int'($urandom_range(99)) < rdy_pct);
        end
    endtask

    task automatic set_w(input int k, input int w);
        bus.weight_i[k*WW +: WW] = WW'(w);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        src_clear();
        bus.dst_ready_i = 1'b0;
        rdy_pct = 100; blk_last = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f_gid.delete(); f_cyc.delete(); f_data.delete();
        r2_seen = 1'b0; gap0 = 0; lstall_max = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.weight_i = '0;
        bus.req_data_i = '0;
        bus.dst_ready_i = 1'b0;
        src_clear();
        rdy_pct = 100; blk_last = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_grant", bus.grant_id_o, 0);
        chk("rst_dst_valid", bus.dst_valid_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 0);
        rst = 1'b0;

        // all four single-beat, weight 1: strict rotation with an idle gap
        do_reset();
        for (int k = 0; k < N; k++) begin set_w(k, 1); src_cfg(k, 1, 1, 1, 0); end
        repeat (14) drive();
        chk("rr_count_ge5", (f_gid.size() >= 5), 1);
        if (f_gid.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", f_gid[i], i % 4);
            chk("rr_gap", f_cyc[1] - f_cyc[0], 2);
        end

        // requester 1, weight 3, two-beat bursts: 6 beats back-to-back, then a gap
        do_reset();
        for (int k = 0; k < N; k++) set_w(k, 0);
        set_w(1, 3);
        src_cfg(1, 1, 2, 2, 0);
        repeat (16) drive();
        chk("w3_count_ge7", (f_gid.size() >= 7), 1);
        if (f_gid.size() >= 7) begin
            for (int i = 1; i < 6; i++) chk("w3_nobubble", f_cyc[i] - f_cyc[i-1], 1);
            chk("w3_regrant_gap", f_cyc[6] - f_cyc[5], 2);
            chk("w3_owner", f_gid[6], 1);
        end

        // weight 0 requester never served
        do_reset();
        set_w(2, 0); set_w(3, 1);
        src_cfg(2, 1, 1, 2, 0); src_cfg(3, 1, 1, 2, 0);
        rdy_pct = 70;
        repeat (40) drive();
        chk("w0_ready2_never", r2_seen, 0);
        chk("w0_some_beats", (f_gid.size() > 0), 1);
        foreach (f_gid[i]) if (f_gid[i] != 3) chk("w0_owner", f_gid[i], 3);

        // owner 0 stalls 3 cycles mid 4-beat burst, requester 1 waiting
        do_reset();
        set_w(0, 1); set_w(1, 1); set_w(2, 0); set_w(3, 0);
        src_cfg(0, 1, 4, 4, 0); hold_at[0] = 1;
        src_cfg(1, 1, 1, 1, 0);
        repeat (20) drive();
        chk("stall_gap_cycles", gap0, 3);
        chk("stall_count_ge5", (f_gid.size() >= 5), 1);
        if (f_gid.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                chk("stall_owner", f_gid[i], 0);
                chk("stall_beat", f_data[i], {8'd0, 24'(i)});
            end
            chk("stall_next_owner", f_gid[4], 1);
        end

        // downstream holds off the last beat for 5 cycles
        do_reset();
        set_w(0, 1); set_w(1, 0);
        src_cfg(0, 1, 3, 3, 0);
        blk_last = 5;
        repeat (15) drive();
        chk("bp_last_stall", lstall_max, 5);
        chk("bp_count_ge3", (f_gid.size() >= 3), 1);
        if (f_gid.size() >= 3) begin
            chk("bp_accept_delay", f_cyc[2] - f_cyc[1], 6);
            chk("bp_last_data", f_data[2], {8'd0, 24'd2});
        end

        // reset mid-burst of requester 2 after the turn pointer moved past 1
        do_reset();
        for (int k = 0; k < N; k++) set_w(k, 1);
        src_cfg(1, 1, 1, 1, 0);
        repeat (6) drive();
        en[1] = 1'b0;
        src_cfg(2, 1, 8, 8, 0);
        repeat (5) drive();
        chk("rst_mid_pre_busy", bus.busy_o, 1);
        chk("rst_mid_pre_grant", bus.grant_id_o, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("rst_mid_busy", bus.busy_o, 0);
        chk("rst_mid_valid", bus.dst_valid_o, 0);
        chk("rst_mid_grant", bus.grant_id_o, 0);
        chk("rst_mid_ready", bus.req_ready_o, 0);
        src_clear();
        src_cfg(1, 1, 1, 1, 0); src_cfg(2, 1, 2, 2, 0);
        f_gid.delete(); f_cyc.delete(); f_data.delete();
        drive();
        rst = 1'b0;
        repeat (6) drive();
        chk("rst_mid_regrant_ge1", (f_gid.size() >= 1), 1);
        if (f_gid.size() >= 1) chk("rst_mid_regrant", f_gid[0], 1);

        // randomized traffic, weights changing at arbitrary times
        do_reset();
        for (int cycle = 0; cycle < 3000; cycle++) begin
            if (cycle % 60 == 0) begin
                for (int k = 0; k < N; k++) begin
                    int lo;
                    set_w(k, int'($urandom_range(3)));
                    lo = int'($urandom_range(4, 1));
                    src_cfg(k, ($urandom_range(3) != 0), lo, int'($urandom_range(4, lo)),
                            int'($urandom_range(30)));
                end
                rdy_pct = int'($urandom_range(100, 50));
            end
            if ($urandom_range(15) == 0) set_w(int'($urandom_range(N-1)), int'($urandom_range(3)));
            if ($urandom_range(199) == 0) blk_last = int'($urandom_range(6, 1));
            drive();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
